// File: rtl/appliance_pkg.sv
// Shared constants and helpers for the appliance controller hub:
// the fixed settings index map, the flat settings bus layout and select widths.
package appliance_pkg;

    localparam int SET_POWER = 0;
    localparam int SET_MODE  = 1;

    // The timer always occupies the last slot, whatever the channel size.
    function automatic int set_timer(input int num_set);
        return num_set - 1;
    endfunction

    function automatic int slice_lo(input int dev, input int set, input int num_set, input int data_w);
        return (dev * num_set + set) * data_w;
    endfunction

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/appliance_ctrl_hub_if.sv
// Addressed settings write port: one strobe-qualified write per cycle,
// answered one cycle later by either an ack or an error pulse.
interface appliance_ctrl_hub_if #(
    parameter int NUM_DEV = 4,
    parameter int NUM_SET = 4,
    parameter int DATA_W  = 5
);
    localparam int DEV_W = appliance_pkg::sel_width(NUM_DEV);
    localparam int SET_W = appliance_pkg::sel_width(NUM_SET);

    logic              wr_en;
    logic [DEV_W-1:0]  dev_sel;
    logic [SET_W-1:0]  set_sel;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              wr_err;

    modport master (
        output wr_en, dev_sel, set_sel, wr_data,
        input  wr_ack, wr_err
    );

    modport slave (
        input  wr_en, dev_sel, set_sel, wr_data,
        output wr_ack, wr_err
    );
endinterface

// File: rtl/appliance_channel.sv
// One appliance channel: settings register file plus the auto-off countdown
// that runs on the shared tick while the channel is powered.
module appliance_channel
    import appliance_pkg::*;
#(
    parameter int NUM_SET = 4,
    parameter int DATA_W  = 5,
    parameter int SET_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      wr_hit,
    input  logic [SET_W-1:0]          set_sel,
    input  logic [DATA_W-1:0]         wr_data,
    output logic [NUM_SET*DATA_W-1:0] settings,
    output logic                      power_on,
    output logic                      timer_done
);
    localparam int TIMER_I = set_timer(NUM_SET);

    logic [DATA_W-1:0] regs_reg [NUM_SET];
    logic              done_reg;
    logic              ctrl_write;
    logic              count_en;
    logic              expire;
    logic              decrement;

    // A write to POWER or TIMER owns the countdown state on that edge, so the tick is dropped.
    always_comb begin
        ctrl_write = wr_hit && ((set_sel == SET_W'(TIMER_I)) || (set_sel == SET_W'(SET_POWER)));
        count_en   = tick && !ctrl_write && (regs_reg[SET_POWER] != '0);
        expire     = count_en && (regs_reg[TIMER_I] == DATA_W'(1));
        decrement  = count_en && (regs_reg[TIMER_I] > DATA_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SET; i++) begin
                regs_reg[i] <= '0;
            end
            done_reg <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SET; i++) begin
                if (wr_hit && (set_sel == SET_W'(i))) begin
                    regs_reg[i] <= wr_data;
                end
            end
            if (expire) begin
                regs_reg[TIMER_I]   <= '0;
                regs_reg[SET_POWER] <= '0;
            end else if (decrement) begin
                regs_reg[TIMER_I] <= regs_reg[TIMER_I] - DATA_W'(1);
            end
            done_reg <= expire;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SET; gi++) begin : g_flat
            assign settings[gi*DATA_W +: DATA_W] = regs_reg[gi];
        end
    endgenerate

    assign power_on   = (regs_reg[SET_POWER] != '0);
    assign timer_done = done_reg;

endmodule

// File: rtl/appliance_ctrl_hub.sv
// Appliance controller hub: shared tick prescaler, write address decode with
// range check, ack/err response, and one appliance_channel per device.
module appliance_ctrl_hub
    import appliance_pkg::*;
#(
    parameter int NUM_DEV  = 4,
    parameter int NUM_SET  = 4,
    parameter int DATA_W   = 5,
    parameter int TICK_DIV = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    appliance_ctrl_hub_if.slave               bus,
    output logic [NUM_DEV-1:0]                power_on,
    output logic [NUM_DEV*NUM_SET*DATA_W-1:0] settings,
    output logic [NUM_DEV-1:0]                timer_done
);
    localparam int          DEV_W   = sel_width(NUM_DEV);
    localparam int          SET_W   = sel_width(NUM_SET);
    localparam int          PRE_W   = $clog2(TICK_DIV);
    localparam logic [31:0] DEV_LIM = NUM_DEV;
    localparam logic [31:0] SET_LIM = NUM_SET;

    logic [PRE_W-1:0]   pre_reg;
    logic               tick;
    logic               in_range;
    logic [NUM_DEV-1:0] wr_hit;
    logic               ack_reg;
    logic               err_reg;

    assign tick = (pre_reg == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_reg <= '0;
        end else if (tick) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + PRE_W'(1);
        end
    end

    // Only matters for non-power-of-two NUM_DEV / NUM_SET, where selects can exceed the range.
    assign in_range = (32'(bus.dev_sel) < DEV_LIM) && (32'(bus.set_sel) < SET_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            ack_reg <= bus.wr_en && in_range;
            err_reg <= bus.wr_en && !in_range;
        end
    end

    assign bus.wr_ack = ack_reg;
    assign bus.wr_err = err_reg;

    generate
        for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_dev
            assign wr_hit[gi] = bus.wr_en && in_range && (bus.dev_sel == DEV_W'(gi));

            appliance_channel #(
                .NUM_SET (NUM_SET),
                .DATA_W  (DATA_W),
                .SET_W   (SET_W)
            ) u_channel (
                .clk        (clk),
                .rst        (rst),
                .tick       (tick),
                .wr_hit     (wr_hit[gi]),
                .set_sel    (bus.set_sel),
                .wr_data    (bus.wr_data),
                .settings   (settings[slice_lo(gi, 0, NUM_SET, DATA_W) +: NUM_SET*DATA_W]),
                .power_on   (power_on[gi]),
                .timer_done (timer_done[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_appliance_ctrl_hub.sv
// Bench for appliance_ctrl_hub: a 4-channel build for the countdown scenarios and
// a 3-channel build for the out-of-range write and mid-countdown reset.
module tb_appliance_ctrl_hub;

    typedef struct {
        logic ack;
        logic err;
        int   cyc;
    } resp_t;

    typedef struct {
        logic [3:0] mask;
        int         cyc;
    } done_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    appliance_ctrl_hub_if #(.NUM_DEV(4), .NUM_SET(4), .DATA_W(5)) bus_a ();
    appliance_ctrl_hub_if #(.NUM_DEV(3), .NUM_SET(4), .DATA_W(5)) bus_b ();

    logic [3:0]  power_a;
    logic [3:0]  done_a;
    logic [79:0] set_a;
    logic [2:0]  power_b;
    logic [2:0]  done_b;
    logic [59:0] set_b;

    appliance_ctrl_hub #(.NUM_DEV(4), .NUM_SET(4), .DATA_W(5), .TICK_DIV(4)) u_dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .bus        (bus_a.slave),
        .power_on   (power_a),
        .settings   (set_a),
        .timer_done (done_a)
    );

    appliance_ctrl_hub #(.NUM_DEV(3), .NUM_SET(4), .DATA_W(5), .TICK_DIV(4)) u_dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .bus        (bus_b.slave),
        .power_on   (power_b),
        .settings   (set_b),
        .timer_done (done_b)
    );

    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    ra;
    int    t;
    resp_t qa[$];
    resp_t qb[$];
    done_t qd[$];
    resp_t ea;
    resp_t eb;
    done_t ed;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] ga(input int d, input int s);
        return set_a[(d*4+s)*5 +: 5];
    endfunction

    function automatic logic [4:0] gb(input int d, input int s);
        return set_b[(d*4+s)*5 +: 5];
    endfunction

    // Response monitor, DUT A: every ack/err pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (bus_a.wr_ack || bus_a.wr_err) begin
            if (qa.size() == 0) begin
                chk("resp_a_unexpected", {126'd0, bus_a.wr_ack, bus_a.wr_err}, 128'd0);
            end else begin
                ea = qa.pop_front();
                chk("resp_a_ack", 128'(bus_a.wr_ack), 128'(ea.ack));
                chk("resp_a_err", 128'(bus_a.wr_err), 128'(ea.err));
                chk("resp_a_cycle", 128'(cyc), 128'(ea.cyc));
            end
        end else if (qa.size() > 0 && qa[0].cyc < cyc) begin
            ea = qa.pop_front();
            chk("resp_a_missing_at", 128'(cyc), 128'(ea.cyc));
        end
    end

    // Auto-off monitor, DUT A.
    always @(negedge clk) begin
        if (done_a != 4'd0) begin
            if (qd.size() == 0) begin
                chk("done_a_unexpected", 128'(done_a), 128'd0);
            end else begin
                ed = qd.pop_front();
                chk("done_a_mask", 128'(done_a), 128'(ed.mask));
                chk("done_a_cycle", 128'(cyc), 128'(ed.cyc));
            end
        end else if (qd.size() > 0 && qd[0].cyc < cyc) begin
            ed = qd.pop_front();
            chk("done_a_missing_at", 128'(cyc), 128'(ed.cyc));
        end
    end

    // Response monitor, DUT B; no auto-off is ever expected there.
    always @(negedge clk) begin
        if (bus_b.wr_ack || bus_b.wr_err) begin
            if (qb.size() == 0) begin
                chk("resp_b_unexpected", {126'd0, bus_b.wr_ack, bus_b.wr_err}, 128'd0);
            end else begin
                eb = qb.pop_front();
                chk("resp_b_ack", 128'(bus_b.wr_ack), 128'(eb.ack));
                chk("resp_b_err", 128'(bus_b.wr_err), 128'(eb.err));
                chk("resp_b_cycle", 128'(cyc), 128'(eb.cyc));
            end
        end else if (qb.size() > 0 && qb[0].cyc < cyc) begin
            eb = qb.pop_front();
            chk("resp_b_missing_at", 128'(cyc), 128'(eb.cyc));
        end
        if (done_b != 3'd0) begin
            chk("done_b_unexpected", 128'(done_b), 128'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_a(input int d, input int s, input int v);
        qa.push_back('{ack: 1'b1, err: 1'b0, cyc: cyc + 1});
        bus_a.wr_en   = 1'b1;
        bus_a.dev_sel = 2'(d);
        bus_a.set_sel = 2'(s);
        bus_a.wr_data = 5'(v);
        @(negedge clk);
        bus_a.wr_en = 1'b0;
    endtask

    task automatic wr_b(input int d, input int s, input int v, input bit ok);
        qb.push_back('{ack: ok, err: !ok, cyc: cyc + 1});
        bus_b.wr_en   = 1'b1;
        bus_b.dev_sel = 2'(d);
        bus_b.set_sel = 2'(s);
        bus_b.wr_data = 5'(v);
        @(negedge clk);
        bus_b.wr_en = 1'b0;
    endtask

    // Prescaler of DUT A was cleared on edge ra; tick edges are ra+4, ra+8, ...
    // Returns one edge after a tick edge, so the next tick is 4 edges away.
    task automatic after_tick();
        while (((cyc + 1 - ra) % 4) != 0) @(negedge clk);
        @(negedge clk);
    endtask

    logic [79:0] mask80;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.wr_en = 1'b0; bus_a.dev_sel = '0; bus_a.set_sel = '0; bus_a.wr_data = '0;
        bus_b.wr_en = 1'b0; bus_b.dev_sel = '0; bus_b.set_sel = '0; bus_b.wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_settings_a", 128'(set_a), 128'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        ra = cyc;

        idle(10);
        chk("idle_settings_a", 128'(set_a), 128'd0);
        chk("idle_power_a", 128'(power_a), 128'd0);
        chk("idle_settings_b", 128'(set_b), 128'd0);

        // Plain storage write
        wr_a(1, 2, 17);
        chk("dev1_set2", 128'(ga(1, 2)), 128'd17);
        mask80 = '0;
        mask80[(1*4+2)*5 +: 5] = 5'h1f;
        chk("others_zero", 128'(set_a & ~mask80), 128'd0);

        // dev2 countdown 3 -> 2 -> 1 -> expire
        after_tick();
        t = cyc;
        wr_a(2, 0, 1);
        wr_a(2, 3, 3);
        qd.push_back('{mask: 4'b0100, cyc: t + 12});
        chk("dev2_power_on", 128'(power_a[2]), 128'd1);
        idle(2);
        chk("dev2_timer_t1", 128'(ga(2, 3)), 128'd2);
        idle(4);
        chk("dev2_timer_t2", 128'(ga(2, 3)), 128'd1);
        chk("dev2_power_mid", 128'(power_a[2]), 128'd1);
        idle(4);
        chk("dev2_timer_t3", 128'(ga(2, 3)), 128'd0);
        chk("dev2_power_off", 128'(power_a[2]), 128'd0);

        // dev0: countdown paused while unpowered, then runs
        after_tick();
        wr_a(0, 3, 2);
        idle(12);
        chk("dev0_timer_paused", 128'(ga(0, 3)), 128'd2);
        chk("dev0_power_off", 128'(power_a[0]), 128'd0);
        after_tick();
        t = cyc;
        wr_a(0, 0, 1);
        qd.push_back('{mask: 4'b0001, cyc: t + 8});
        idle(3);
        chk("dev0_timer_t1", 128'(ga(0, 3)), 128'd1);
        idle(4);
        chk("dev0_timer_t2", 128'(ga(0, 3)), 128'd0);
        chk("dev0_power_expired", 128'(power_a[0]), 128'd0);

        // dev3: TIMER reload on the expiring tick wins
        after_tick();
        t = cyc;
        wr_a(3, 0, 1);
        wr_a(3, 3, 1);
        idle(1);
        wr_a(3, 3, 5);
        chk("dev3_reload", 128'(ga(3, 3)), 128'd5);
        chk("dev3_power_kept", 128'(power_a[3]), 128'd1);
        idle(4);
        chk("dev3_after_tick", 128'(ga(3, 3)), 128'd4);
        wr_a(3, 0, 0);
        idle(8);
        chk("dev3_paused", 128'(ga(3, 3)), 128'd4);

        // dev1: MODE write on a tick edge does not stop the countdown
        after_tick();
        wr_a(1, 0, 1);
        wr_a(1, 3, 3);
        idle(1);
        wr_a(1, 1, 9);
        chk("dev1_mode", 128'(ga(1, 1)), 128'd9);
        chk("dev1_timer_ticked", 128'(ga(1, 3)), 128'd2);
        wr_a(1, 0, 0);
        idle(3);
        chk("dev1_set2_kept", 128'(ga(1, 2)), 128'd17);

        // 3-channel build: out-of-range write, then mid-countdown reset
        wr_b(3, 0, 7, 1'b0);
        chk("b_oor_no_change", 128'(set_b), 128'd0);
        wr_b(2, 0, 1, 1'b1);
        wr_b(2, 3, 3, 1'b1);
        wr_b(3, 3, 9, 1'b0);
        chk("b_dev2_power", 128'(gb(2, 0)), 128'd1);
        chk("b_power_on", 128'(power_b), 128'b100);
        idle(5);
        rst_b = 1'b1;
        @(negedge clk);
        chk("b_rst_settings", 128'(set_b), 128'd0);
        chk("b_rst_power", 128'(power_b), 128'd0);
        rst_b = 1'b0;

        idle(6);
        chk("qa_drained", 128'(qa.size()), 128'd0);
        chk("qb_drained", 128'(qb.size()), 128'd0);
        chk("qd_drained", 128'(qd.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
